// File: rtl/main_cache_fill_ctrl.sv
// Cache line-fill controller: captures a miss, reads the line from memory,
// streams words into the data array, writes the tag and maintains per-set tree-PLRU.
module main_cache_fill_ctrl #(
    parameter int  LINE_WORDS = 8,
    parameter int  SET_BITS   = 11,
    localparam int WI_W       = $clog2(LINE_WORDS)
) (
    input  logic              main_clk,
    input  logic              main_rst_n,
    input  logic              access_valid,
    input  logic              hit_hard_fault,
    input  logic [1:0]        hit_way_index,
    input  logic [30:0]       target_address,
    output logic              mem_req,
    output logic [25:0]       mem_addr,
    input  logic              mem_ack,
    input  logic              mem_rvalid,
    input  logic [15:0]       mem_rdata,
    output logic [30:0]       fill_address,
    output logic [1:0]        fill_way_index,
    output logic              fill_tag_write,
    output logic              fill_data_we,
    output logic [WI_W-1:0]   fill_word_index,
    output logic [15:0]       fill_data,
    output logic              busy,
    output logic              done
);
    localparam int NSETS = 1 << SET_BITS;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_FILL, S_COMMIT} state_e;

    state_e            state_q, state_d;
    logic [30:0]       fill_address_q, fill_address_d;
    logic [1:0]        victim_q, victim_d;
    logic [WI_W-1:0]   cnt_q, cnt_d;
    logic              mem_req_q, mem_req_d;
    logic              tag_write_q, tag_write_d;
    logic              data_we_q, data_we_d;
    logic [WI_W-1:0]   widx_q, widx_d;
    logic [15:0]       wdata_q, wdata_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [2:0]          plru_q [NSETS];
    logic                plru_we;
    logic [SET_BITS-1:0] plru_wset;
    logic [2:0]          plru_wval;
    logic [SET_BITS-1:0] acc_set, fill_set;

    function automatic logic [1:0] plru_victim(input logic [2:0] b);
        return b[0] ? (b[2] ? 2'd3 : 2'd2) : (b[1] ? 2'd1 : 2'd0);
    endfunction

    // Point the tree away from the way just touched; the other subtree bit is kept.
    function automatic logic [2:0] plru_touch(input logic [2:0] b, input logic [1:0] w);
        logic [2:0] n;
        n = b;
        if (!w[1]) begin
            n[0] = 1'b1;
            n[1] = ~w[0];
        end else begin
            n[0] = 1'b0;
            n[2] = ~w[0];
        end
        return n;
    endfunction

    assign acc_set  = target_address[4 +: SET_BITS];
    assign fill_set = fill_address_q[4 +: SET_BITS];

    // Single PLRU write port: IDLE hits and the COMMIT of a fill never overlap.
    always_comb begin
        plru_we   = 1'b0;
        plru_wset = acc_set;
        plru_wval = plru_touch(plru_q[acc_set], hit_way_index);
        if (state_q == S_IDLE && access_valid && !hit_hard_fault) begin
            plru_we = 1'b1;
        end else if (state_q == S_COMMIT) begin
            plru_we   = 1'b1;
            plru_wset = fill_set;
            plru_wval = plru_touch(plru_q[fill_set], victim_q);
        end
    end

    always_ff @(posedge main_clk or negedge main_rst_n) begin
        if (!main_rst_n) begin
            for (int s = 0; s < NSETS; s++) plru_q[s] <= '0;
        end else if (plru_we) begin
            plru_q[plru_wset] <= plru_wval;
        end
    end

    always_comb begin
        state_d        = state_q;
        fill_address_d = fill_address_q;
        victim_d       = victim_q;
        cnt_d          = cnt_q;
        mem_req_d      = 1'b0;
        tag_write_d    = 1'b0;
        data_we_d      = 1'b0;
        widx_d         = widx_q;
        wdata_d        = wdata_q;
        done_d         = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (access_valid && hit_hard_fault) begin
                    fill_address_d = target_address;
                    victim_d       = plru_victim(plru_q[acc_set]);
                    mem_req_d      = 1'b1;
                    state_d        = S_REQ;
                end
            end
            S_REQ: begin
                if (mem_ack) begin
                    cnt_d   = '0;
                    state_d = S_FILL;
                end else begin
                    mem_req_d = 1'b1;
                end
            end
            S_FILL: begin
                if (mem_rvalid) begin
                    data_we_d = 1'b1;
                    widx_d    = cnt_q;
                    wdata_d   = mem_rdata;
                    if (cnt_q == WI_W'(LINE_WORDS - 1)) begin
                        cnt_d       = '0;
                        tag_write_d = 1'b1;
                        done_d      = 1'b1;
                        state_d     = S_COMMIT;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_COMMIT: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge main_clk or negedge main_rst_n) begin
        if (!main_rst_n) begin
            state_q        <= S_IDLE;
            fill_address_q <= '0;
            victim_q       <= '0;
            cnt_q          <= '0;
            mem_req_q      <= 1'b0;
            tag_write_q    <= 1'b0;
            data_we_q      <= 1'b0;
            widx_q         <= '0;
            wdata_q        <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            fill_address_q <= fill_address_d;
            victim_q       <= victim_d;
            cnt_q          <= cnt_d;
            mem_req_q      <= mem_req_d;
            tag_write_q    <= tag_write_d;
            data_we_q      <= data_we_d;
            widx_q         <= widx_d;
            wdata_q        <= wdata_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
        end
    end

    assign mem_req         = mem_req_q;
    assign mem_addr        = {fill_address_q[25:4], 4'b0000};
    assign fill_address    = fill_address_q;
    // Tag stage samples the way a cycle ahead of the write, so the victim is shown for the whole fill.
    assign fill_way_index  = busy_q ? victim_q : hit_way_index;
    assign fill_tag_write  = tag_write_q;
    assign fill_data_we    = data_we_q;
    assign fill_word_index = widx_q;
    assign fill_data       = wdata_q;
    assign busy            = busy_q;
    assign done            = done_q;
endmodule

// File: tb/tb_main_cache_fill_ctrl.sv
// Self-checking bench for main_cache_fill_ctrl: directed scenarios plus random
// hit/miss traffic checked against an MRU-tracking PLRU model.
module tb_main_cache_fill_ctrl;
    localparam int LW = 8;
    localparam int SB = 11;
    localparam int NS = 1 << SB;

    logic        main_clk = 1'b0;
    logic        main_rst_n = 1'b0;
    logic        access_valid = 1'b0, hit_hard_fault = 1'b0;
    logic [1:0]  hit_way_index = '0;
    logic [30:0] target_address = '0;
    logic        mem_req, mem_ack = 1'b0, mem_rvalid = 1'b0;
    logic [25:0] mem_addr;
    logic [15:0] mem_rdata = '0;
    logic [30:0] fill_address;
    logic [1:0]  fill_way_index;
    logic        fill_tag_write, fill_data_we, busy, done;
    logic [2:0]  fill_word_index;
    logic [15:0] fill_data;

    main_cache_fill_ctrl #(.LINE_WORDS(LW), .SET_BITS(SB)) dut (
        .main_clk(main_clk), .main_rst_n(main_rst_n),
        .access_valid(access_valid), .hit_hard_fault(hit_hard_fault),
        .hit_way_index(hit_way_index), .target_address(target_address),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .fill_address(fill_address), .fill_way_index(fill_way_index),
        .fill_tag_write(fill_tag_write), .fill_data_we(fill_data_we),
        .fill_word_index(fill_word_index), .fill_data(fill_data),
        .busy(busy), .done(done)
    );

    always #5 main_clk = ~main_clk;

    int errors = 0, checks = 0;

    // Reference PLRU: which pair of ways was used last, and the last-used way inside each pair.
    int pair_mru [NS];
    int mru_lo   [NS];
    int mru_hi   [NS];

    function automatic void model_reset();
        for (int s = 0; s < NS; s++) begin
            pair_mru[s] = 1;
            mru_lo[s]   = 1;
            mru_hi[s]   = 3;
        end
    endfunction

    function automatic int model_victim(int s);
        if (pair_mru[s] == 0) return (mru_hi[s] == 3) ? 2 : 3;
        return (mru_lo[s] == 1) ? 0 : 1;
    endfunction

    function automatic void model_touch(int s, int w);
        pair_mru[s] = w / 2;
        if (w < 2) mru_lo[s] = w;
        else       mru_hi[s] = w;
    endfunction

    function automatic int set_of(logic [30:0] a);
        return int'(a >> 4) % NS;
    endfunction

    // Output monitor
    int          mon_widx [$];
    logic [15:0] mon_wdata [$];
    int          tagw_cnt, done_cnt, busy_rises, min_idle_gap, idle_run;
    logic [1:0]  tagw_way;
    logic        prev_busy;

    always @(negedge main_clk) begin
        if (main_rst_n) begin
            if (fill_data_we) begin
                mon_widx.push_back(int'(fill_word_index));
                mon_wdata.push_back(fill_data);
            end
            if (fill_tag_write) begin
                tagw_cnt++;
                tagw_way = fill_way_index;
            end
            if (done) done_cnt++;
            if (busy && !prev_busy) begin
                busy_rises++;
                if (idle_run < min_idle_gap) min_idle_gap = idle_run;
            end
            idle_run  = busy ? 0 : idle_run + 1;
            prev_busy = busy;
        end
    end

    task automatic clear_mon();
        mon_widx.delete();
        mon_wdata.delete();
        tagw_cnt = 0; done_cnt = 0; busy_rises = 0;
        min_idle_gap = 1000; idle_run = 1000; prev_busy = busy;
        tagw_way = '0;
    endtask

    task automatic step();
        @(negedge main_clk);
        #1;
    endtask

    logic [1:0]  obs_way;
    logic [25:0] obs_mem_addr;
    logic [30:0] obs_fill_addr;
    int          obs_req_low;
    bit          obs_timeout;

    // Drives one miss through the memory handshake; records observations only.
    task automatic do_fill(input logic [30:0] addr, input int ack_dly, input int gap,
                           input logic [15:0] base, input bit hold, input bit spur, input int nwords);
        int n;
        obs_timeout = 0; obs_req_low = 0;
        access_valid = 1; hit_hard_fault = 1; target_address = addr;
        n = 0;
        do begin step(); n++; end while (!busy && n < 20);
        if (!busy) begin
            obs_timeout = 1; access_valid = 0; hit_hard_fault = 0;
            return;
        end
        obs_way = fill_way_index; obs_mem_addr = mem_addr; obs_fill_addr = fill_address;
        if (!hold) begin access_valid = 0; hit_hard_fault = 0; end
        for (int i = 0; i < ack_dly; i++) begin
            if (!mem_req) obs_req_low++;
            if (spur) begin mem_rvalid = 1; mem_rdata = 16'hDEAD; end
            step();
            mem_rvalid = 0;
        end
        if (!mem_req) obs_req_low++;
        mem_ack = 1; step(); mem_ack = 0;
        for (int k = 0; k < nwords; k++) begin
            for (int g = 0; g < gap; g++) begin
                if (spur) mem_ack = 1;
                step();
                mem_ack = 0;
            end
            mem_rvalid = 1; mem_rdata = 16'(base + k); step(); mem_rvalid = 0;
        end
        if (nwords < LW) return;
        n = 0;
        while (busy && n < 20) begin step(); n++; end
        if (busy) obs_timeout = 1;
    endtask

    task automatic do_hit(input logic [30:0] addr, input logic [1:0] way);
        access_valid = 1; hit_hard_fault = 0; hit_way_index = way; target_address = addr;
        step();
        access_valid = 0;
    endtask

    task automatic apply_reset();
        main_rst_n = 0;
        step(); step();
        main_rst_n = 1;
        model_reset();
        step();
    endtask

    task automatic test_reset();
        logic [108:0] outs;
        main_rst_n = 0;
        step(); step();
        outs = {mem_req, mem_addr, fill_address, fill_tag_write, fill_data_we,
                fill_word_index, fill_data, busy, done};
        checks++;
        if (outs !== '0) begin errors++; $display("FAIL reset_outputs: got %0h want 0", outs); end
        main_rst_n = 1;
        model_reset();
        step(); step();
        checks++;
        if (busy !== 1'b0 || mem_req !== 1'b0) begin
            errors++; $display("FAIL reset_idle: busy=%b mem_req=%b want 0 0", busy, mem_req);
        end
    endtask

    task automatic test_basic_fill();
        bit bad;
        clear_mon();
        do_fill(31'h0001_2340, 3, 0, 16'hA000, 0, 0, LW);
        checks++;
        if (obs_timeout) begin errors++; $display("FAIL basic_timeout: fill did not complete"); end
        checks++;
        if (obs_mem_addr !== 26'h0012340) begin errors++; $display("FAIL basic_mem_addr: got %0h want 12340", obs_mem_addr); end
        checks++;
        if (obs_fill_addr !== 31'h0001_2340) begin errors++; $display("FAIL basic_fill_addr: got %0h want 12340", obs_fill_addr); end
        checks++;
        if (obs_req_low != 0) begin errors++; $display("FAIL basic_req_held: mem_req low %0d cycles want 0", obs_req_low); end
        checks++;
        if (obs_way !== 2'd0 || tagw_way !== 2'd0) begin
            errors++; $display("FAIL basic_way: req=%0d commit=%0d want 0", obs_way, tagw_way);
        end
        checks++;
        if (mon_widx.size() != LW) begin errors++; $display("FAIL basic_write_count: got %0d want %0d", mon_widx.size(), LW); end
        bad = 0;
        for (int k = 0; k < mon_widx.size() && k < LW; k++)
            if (mon_widx[k] != k || mon_wdata[k] !== 16'hA000 + 16'(k)) bad = 1;
        checks++;
        if (bad) begin errors++; $display("FAIL basic_write_data: index/data sequence got %p want 0..7 with A000..A007", mon_widx); end
        checks++;
        if (tagw_cnt != 1 || done_cnt != 1) begin
            errors++; $display("FAIL basic_commit: tag_writes=%0d dones=%0d want 1 1", tagw_cnt, done_cnt);
        end
        model_touch(set_of(31'h0001_2340), 0);
    endtask

    task automatic test_victim_order();
        int exp_v [4] = '{2, 1, 3, 0};
        logic [30:0] a;
        for (int i = 0; i < 4; i++) begin
            a = 31'h0001_2340 + 31'((i + 1) * 32'h8000);
            clear_mon();
            do_fill(a, i, 0, 16'h1000 * 16'(i + 1), 0, 0, LW);
            checks++;
            if (obs_timeout || int'(obs_way) != exp_v[i] || int'(tagw_way) != exp_v[i] || tagw_cnt != 1) begin
                errors++;
                $display("FAIL victim_order[%0d]: req_way=%0d commit_way=%0d tag_writes=%0d want way %0d once",
                         i, obs_way, tagw_way, tagw_cnt, exp_v[i]);
            end
            model_touch(set_of(a), exp_v[i]);
        end
    endtask

    task automatic test_hit_plru();
        apply_reset();
        access_valid = 1; hit_hard_fault = 0; hit_way_index = 2'd2; target_address = 31'h50;
        #1;
        checks++;
        if (fill_way_index !== 2'd2) begin errors++; $display("FAIL idle_way_passthru: got %0d want 2", fill_way_index); end
        step();
        access_valid = 0;
        do_hit(31'h50, 2'd0);
        model_touch(5, 2); model_touch(5, 0);
        clear_mon();
        do_fill(31'h0001_0050, 1, 0, 16'h5000, 0, 0, LW);
        checks++;
        if (obs_timeout || obs_way !== 2'd3 || tagw_way !== 2'd3) begin
            errors++; $display("FAIL hit_plru_victim: req=%0d commit=%0d want 3", obs_way, tagw_way);
        end
        model_touch(5, 3);
    endtask

    task automatic test_spurious();
        bit bad;
        int v;
        logic [30:0] a;
        a = 31'h0000_0070;
        v = model_victim(set_of(a));
        clear_mon();
        do_fill(a, 3, 2, 16'h7700, 0, 1, LW);
        checks++;
        if (obs_timeout || mon_widx.size() != LW) begin
            errors++; $display("FAIL spurious_count: writes=%0d timeout=%0d want %0d 0", mon_widx.size(), obs_timeout, LW);
        end
        bad = 0;
        for (int k = 0; k < mon_widx.size() && k < LW; k++)
            if (mon_widx[k] != k || mon_wdata[k] !== 16'h7700 + 16'(k)) bad = 1;
        checks++;
        if (bad) begin errors++; $display("FAIL spurious_data: index sequence got %p want 0..7", mon_widx); end
        checks++;
        if (tagw_cnt != 1 || int'(tagw_way) != v) begin
            errors++; $display("FAIL spurious_commit: tag_writes=%0d way=%0d want 1 %0d", tagw_cnt, tagw_way, v);
        end
        model_touch(set_of(a), v);
    endtask

    task automatic test_reset_mid_fill();
        logic [108:0] outs;
        clear_mon();
        do_fill(31'h0000_0090, 1, 0, 16'hB000, 0, 0, 4);
        checks++;
        if (mon_widx.size() != 4 || busy !== 1'b1) begin
            errors++; $display("FAIL midfill_progress: writes=%0d busy=%b want 4 1", mon_widx.size(), busy);
        end
        main_rst_n = 0;
        #1;
        outs = {mem_req, mem_addr, fill_address, fill_tag_write, fill_data_we,
                fill_word_index, fill_data, busy, done};
        checks++;
        if (outs !== '0) begin errors++; $display("FAIL midfill_reset_outputs: got %0h want 0", outs); end
        step(); step();
        main_rst_n = 1;
        model_reset();
        step();
        checks++;
        if (tagw_cnt != 0) begin errors++; $display("FAIL midfill_no_tag: tag_writes=%0d want 0", tagw_cnt); end
        clear_mon();
        do_fill(31'h0000_00A0, 0, 0, 16'hC000, 0, 0, LW);
        checks++;
        if (obs_timeout || mon_widx.size() != LW || mon_widx[0] != 0 || mon_wdata[0] !== 16'hC000 || obs_way !== 2'd0) begin
            errors++; $display("FAIL midfill_restart: writes=%0d first_idx=%0d way=%0d want %0d 0 0",
                               mon_widx.size(), (mon_widx.size() > 0) ? mon_widx[0] : -1, obs_way, LW);
        end
        model_touch(set_of(31'h0000_00A0), 0);
    endtask

    task automatic test_busy_hold();
        int v1, v2, s;
        logic [1:0] w1;
        logic [30:0] a;
        a = 31'h0000_0100;
        s = set_of(a);
        clear_mon();
        v1 = model_victim(s);
        do_fill(a, 1, 0, 16'hD000, 1, 0, LW);
        w1 = obs_way;
        model_touch(s, v1);
        v2 = model_victim(s);
        do_fill(a, 2, 1, 16'hE000, 1, 0, LW);
        access_valid = 0; hit_hard_fault = 0;
        model_touch(s, v2);
        step(); step();
        checks++;
        if (int'(w1) != v1 || int'(obs_way) != v2) begin
            errors++; $display("FAIL hold_victims: got %0d %0d want %0d %0d", w1, obs_way, v1, v2);
        end
        checks++;
        if (busy_rises != 2 || tagw_cnt != 2 || done_cnt != 2 || mon_widx.size() != 2 * LW) begin
            errors++; $display("FAIL hold_fill_count: rises=%0d tags=%0d dones=%0d writes=%0d want 2 2 2 %0d",
                               busy_rises, tagw_cnt, done_cnt, mon_widx.size(), 2 * LW);
        end
        checks++;
        if (min_idle_gap < 1 || min_idle_gap >= 1000) begin
            errors++; $display("FAIL hold_idle_gap: got %0d want >=1", min_idle_gap);
        end
    endtask

    task automatic test_random();
        int s, w, v;
        bit bad;
        logic [30:0] a;
        logic [25:0] ema;
        logic [15:0] base;
        for (int it = 0; it < 30; it++) begin
            s = 16 + $urandom_range(0, 3);
            a = (31'($urandom) & 31'h7FFF_8000) | 31'(s << 4) | 31'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 0) begin
                w = $urandom_range(0, 3);
                do_hit(a, 2'(w));
                model_touch(s, w);
            end else begin
                v = model_victim(s);
                ema = {a[25:4], 4'b0000};
                base = 16'($urandom);
                clear_mon();
                do_fill(a, $urandom_range(0, 4), $urandom_range(0, 2), base, 0, 0, LW);
                bad = (mon_widx.size() != LW);
                for (int k = 0; k < mon_widx.size() && k < LW; k++)
                    if (mon_widx[k] != k || mon_wdata[k] !== 16'(base + k)) bad = 1;
                checks++;
                if (obs_timeout || int'(obs_way) != v || int'(tagw_way) != v || obs_mem_addr !== ema || bad || tagw_cnt != 1) begin
                    errors++;
                    $display("FAIL random_fill[%0d]: way=%0d/%0d addr=%0h data_bad=%0d tags=%0d want way %0d addr %0h",
                             it, obs_way, tagw_way, obs_mem_addr, bad, tagw_cnt, v, ema);
                end
                model_touch(s, v);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        model_reset();
        clear_mon();
        test_reset();
        test_basic_fill();
        test_victim_order();
        test_hit_plru();
        test_spurious();
        test_reset_mid_fill();
        test_busy_hold();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/main_cache_fill_ctrl.md
MAIN_CACHE_FILL_CTRL -- requirements
Module: main_cache_fill_ctrl

Interface
REQ-001 Parameter LINE_WORDS, default 8, is the number of 16-bit words per cache line; it SHALL be a power of two, 2..16.
REQ-002 Parameter SET_BITS, default 11, is the width of the set index target_address[14:4].
REQ-003 main_clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-004 main_rst_n  in  1  reset, asynchronous, active-low.
REQ-005 access_valid  in  1  a core access is being looked up this cycle.
REQ-006 hit_hard_fault  in  1  miss indication from the tag-way stage, valid in the same cycle as access_valid.
REQ-007 hit_way_index  in  2  way that matched, valid when access_valid && !hit_hard_fault.
REQ-008 target_address  in  31  address of the current access.
REQ-009 mem_req  out  1  line-read request to memory.
REQ-010 mem_addr  out  26  line-aligned byte address {line[25:4], 4'b0}.
REQ-011 mem_ack  in  1  memory accepts the request.
REQ-012 mem_rvalid / mem_rdata  in  1 / 16  returned read word strobe and data.
REQ-013 fill_address  out  31  latched miss address; the upstream mux SHALL drive it to the tag stage while busy.
REQ-014 fill_way_index  out  2  way index to the tag stage.
REQ-015 fill_tag_write  out  1  tag write strobe (tag stage do_write).
REQ-016 fill_data_we / fill_word_index / fill_data  out  1 / log2(LINE_WORDS) / 16  data-array write port.
REQ-017 busy  out  1  high in any state other than IDLE; done  out  1  single-cycle fill-complete pulse.

Function
REQ-018 States: IDLE, REQ, FILL, COMMIT; reset state IDLE.
REQ-019 IDLE: access_valid && hit_hard_fault SHALL latch target_address into fill_address, latch victim way from PLRU[target_address[14:4]], and enter REQ next cycle.
REQ-020 REQ: mem_req=1, mem_addr from fill_address, held until a cycle with mem_ack=1; that cycle SHALL transition to FILL with word counter 0.
REQ-021 FILL: each mem_rvalid=1 cycle SHALL produce, one cycle later, fill_data_we=1, fill_word_index=counter, fill_data=mem_rdata; counter increments, wrapping to 0 after LINE_WORDS-1.
REQ-022 FILL SHALL move to COMMIT on the cycle the LINE_WORDS-th word is accepted; COMMIT lasts exactly one cycle, then IDLE.
REQ-023 COMMIT: fill_tag_write=1, done=1, and PLRU for the latched set SHALL be updated as an access to the victim way.
REQ-024 fill_way_index SHALL equal the latched victim from the REQ cycle through COMMIT inclusive (the tag stage samples it one cycle before the write), and equal hit_way_index in IDLE.
REQ-025 PLRU: 3 bits {b2,b1,b0} per set, 2**SET_BITS sets; victim = b0 ? (b2 ? 3 : 2) : (b1 ? 1 : 0).
REQ-026 PLRU update on access to way w: if w[1]==0 then b0<=1, b1<=~w[0]; else b0<=0, b2<=~w[0]; unused bit unchanged.
REQ-027 In IDLE, access_valid && !hit_hard_fault SHALL update PLRU for that set with hit_way_index.
REQ-028 hit_hard_fault and access_valid SHALL be ignored while busy; no PLRU hit updates while busy.
REQ-029 mem_rvalid outside FILL, or mem_ack outside REQ, SHALL be ignored.
REQ-030 IDLE miss and COMMIT never coincide (COMMIT is not IDLE); a miss presented during COMMIT is ignored and the requester SHALL re-present it.

Reset
REQ-031 main_rst_n low SHALL immediately force IDLE, counter 0, all PLRU bits 0, fill_address 0, and mem_req, fill_tag_write, fill_data_we, done, busy, fill_word_index, fill_data, mem_addr all 0.
REQ-032 Reset asserted mid-FILL SHALL abandon the fill with no tag write; words already written are not retracted.

Verification
REQ-033 Reset, miss at address 0x0001_2340, ack after 3 cycles, 8 rvalid words 0xA000..0xA007 -> mem_addr 0x0012340, 8 writes indices 0..7 with matching data, fill_way_index 0, one COMMIT with fill_tag_write=1, done=1.
REQ-034 Same set after fill of way 0 -> next miss victims 2, 1, 3, 0 in order across four successive fills.
REQ-035 Hits on ways 0 and 2 to set 5 from reset -> PLRU set 5 = {b2=1,b1=1,b0=1}; next miss in set 5 picks way 3.
REQ-036 mem_rvalid pulses during REQ and mem_ack during FILL -> no data writes, no state change; gapped rvalid (1 word every 3 cycles) -> fill completes after exactly 8 accepted words.
REQ-037 main_rst_n low after 4 words in FILL -> all outputs 0 same cycle, no fill_tag_write, next miss restarts at word 0.
REQ-038 hit_hard_fault asserted every cycle while busy -> exactly one fill per miss accepted in IDLE, busy drops for at least one cycle between fills.
